wb_sram_responder: RTL

WB_SRAM_RESPONDER -- requirements
Module: wb_sram_responder

---
 rtl/wb_sram_responder.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/wb_sram_responder.sv
//------------------------------------------------------------------------------
// Module   : wb_sram_responder
// Brief    : Wishbone-style SRAM slave with wait states, RO region, error resp.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module wb_sram_responder #(
    parameter int XLEN        = 32,
    parameter int ADDR_WIDTH  = 8,
    parameter int WAIT_STATES = 1,
    parameter int RO_WORDS    = 16
) (
    input  logic                  clk_i,
    input  logic                  clear_ni,
    input  logic                  stb_i,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] adr_i,
    input  logic [3:0]            sel_i,
    input  logic [XLEN-1:0]       dat_i,
    output logic [XLEN-1:0]       dat_o,
    output logic                  ack_o,
    output logic                  err_o,
    output logic                  busy_o
);

    localparam int          c_DEPTH    = 2 ** ADDR_WIDTH;
    localparam logic [3:0]  c_WAIT     = WAIT_STATES[3:0];
    localparam logic        c_NO_WAIT  = (WAIT_STATES == 0);
    localparam logic [31:0] c_RO_LIMIT = RO_WORDS;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_WAIT    = 2'd1,
        S_RESP    = 2'd2,
        S_RECOVER = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic [3:0]            r_cnt;
    logic                  r_we;
    logic [ADDR_WIDTH-1:0] r_adr;
    logic [3:0]            r_sel;
    logic [XLEN-1:0]       r_dat;
    logic                  r_err;
    logic [XLEN-1:0]       r_rdata;
    logic                  r_ack;
    logic                  r_errp;

    // Zero at configuration; deliberately outside the reset domain.
    logic [XLEN-1:0]       r_mem [c_DEPTH] = '{default: '0};

    logic                  w_cap;
    logic                  w_err_in;
    logic                  w_we;
    logic [ADDR_WIDTH-1:0] w_adr;
    logic [3:0]            w_sel;
    logic [XLEN-1:0]       w_dat;
    logic                  w_err;
    logic                  w_enter_resp;
    logic                  w_commit;
    logic                  w_load_rd;

    // With no wait states RESP is entered on the capture edge itself, so the
    // transaction fields come straight from the inputs in IDLE.
    assign w_cap    = (r_state == S_IDLE);
    assign w_err_in = (sel_i == 4'b0000) || (we_i && (32'(adr_i) < c_RO_LIMIT));
    assign w_we     = w_cap ? we_i     : r_we;
    assign w_adr    = w_cap ? adr_i    : r_adr;
    assign w_sel    = w_cap ? sel_i    : r_sel;
    assign w_dat    = w_cap ? dat_i    : r_dat;
    assign w_err    = w_cap ? w_err_in : r_err;

    assign w_commit  = w_enter_resp && clear_ni && w_we && !w_err;
    assign w_load_rd = w_enter_resp && clear_ni && !w_we && !w_err;

    always_comb begin
        w_next       = r_state;
        w_enter_resp = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (stb_i) begin
                    if (c_NO_WAIT) begin
                        w_next       = S_RESP;
                        w_enter_resp = 1'b1;
                    end else begin
                        w_next = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (!stb_i) begin
                    w_next = S_IDLE;
                end else if (r_cnt == 4'd1) begin
                    w_next       = S_RESP;
                    w_enter_resp = 1'b1;
                end
            end
            S_RESP: begin
                w_next = S_RECOVER;
            end
            S_RECOVER: begin
                if (!stb_i) begin
                    w_next = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!clear_ni) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
            r_we    <= 1'b0;
            r_adr   <= '0;
            r_sel   <= 4'd0;
            r_dat   <= '0;
            r_err   <= 1'b0;
            r_rdata <= '0;
            r_ack   <= 1'b0;
            r_errp  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_ack   <= w_enter_resp && !w_err;
            r_errp  <= w_enter_resp && w_err;
            if (w_cap && stb_i) begin
                r_we  <= we_i;
                r_adr <= adr_i;
                r_sel <= sel_i;
                r_dat <= dat_i;
                r_err <= w_err_in;
                r_cnt <= c_WAIT;
            end else if ((r_state == S_WAIT) && (r_cnt != 4'd0)) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if (w_load_rd) begin
                r_rdata <= r_mem[w_adr];
            end
        end
    end

    // Byte-lane write port; lanes with a clear select bit keep their value.
    always_ff @(posedge clk_i) begin
        if (w_commit) begin
            for (int b = 0; b < 4; b++) begin
                if (w_sel[b]) begin
                    r_mem[w_adr][8*b +: 8] <= w_dat[8*b +: 8];
                end
            end
        end
    end

    assign dat_o  = r_rdata;
    assign ack_o  = r_ack;
    assign err_o  = r_errp;
    assign busy_o = (r_state != S_IDLE);

endmodule

`default_nettype wire
